// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and iteration-engine modes for seq_alu.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // LOAD is the single register stage between the accept edge and DONE/BUSY.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Shared mul/div iteration engine: shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator ({high half, low shift half}) and one counter.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   init,
  input  logic [WIDTH-1:0]   opnd,
  output logic               done,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               mode_reg;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_part;
  logic [WIDTH:0] div_trial;

  always_comb begin
    acc_next  = acc_reg;
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_part  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_trial = div_part - {1'b0, opnd_reg};
    if (mode_reg == MODE_DIV) begin
      // Partial remainder stays below the divisor, so the restored value fits WIDTH bits.
      if (!div_trial[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      else
        acc_next = {div_part[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      opnd_reg <= '0;
      mode_reg <= MODE_MUL;
      cnt_reg  <= '0;
    end else if (start) begin
      acc_reg  <= {{WIDTH{1'b0}}, init};
      opnd_reg <= opnd;
      mode_reg <= mode;
      cnt_reg  <= CW'(WIDTH);
    end else if (cnt_reg != '0) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign done = (cnt_reg == '0);
  assign acc  = acc_reg;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU with valid/ready on both sides; one operation in flight.
// Add/sub/error finish in LOAD, mul/div run WIDTH iterations in seq_alu_iter.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               swap,
  output logic               err
);

  state_t state_reg;

  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   big_reg;
  logic [WIDTH-1:0]   small_reg;
  logic               swap_pend_reg;
  logic               err_pend_reg;
  logic [2*WIDTH-1:0] result_reg;
  logic               swap_reg;
  logic               err_reg;

  logic               accept;
  logic               b_gt_a;
  logic [WIDTH-1:0]   big_c;
  logic [WIDTH-1:0]   small_c;
  logic               is_div;
  logic               swap_c;
  logic               err_c;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_acc;
  logic [2*WIDTH-1:0] quick_result;
  logic               needs_iter;

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign accept    = in_valid && in_ready;

  assign b_gt_a  = (b > a);
  assign big_c   = b_gt_a ? b : a;
  assign small_c = b_gt_a ? a : b;
  assign is_div  = (code == OP_DIV);
  assign swap_c  = ((code == OP_SUB) || is_div) && b_gt_a;
  assign err_c   = code[2] || (is_div && (small_c == '0));

  // The engine is armed on every accept; its result is only used for mul/div.
  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .mode  (is_div ? MODE_DIV : MODE_MUL),
    .init  (is_div ? big_c : b),
    .opnd  (is_div ? small_c : a),
    .done  (iter_done),
    .acc   (iter_acc)
  );

  assign needs_iter = !err_pend_reg && ((op_reg == OP_MUL) || (op_reg == OP_DIV));

  always_comb begin
    quick_result = '0;
    if (err_pend_reg) begin
      if (!op_reg[2])
        quick_result = {big_reg, {WIDTH{1'b1}}};
    end else if (op_reg == OP_ADD) begin
      quick_result = {{(WIDTH-1){1'b0}}, {1'b0, big_reg} + {1'b0, small_reg}};
    end else if (op_reg == OP_SUB) begin
      quick_result = {{WIDTH{1'b0}}, big_reg - small_reg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      big_reg       <= '0;
      small_reg     <= '0;
      swap_pend_reg <= 1'b0;
      err_pend_reg  <= 1'b0;
      result_reg    <= '0;
      swap_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg        <= code;
            big_reg       <= big_c;
            small_reg     <= small_c;
            swap_pend_reg <= swap_c;
            err_pend_reg  <= err_c;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (needs_iter) begin
            state_reg <= ST_BUSY;
          end else begin
            result_reg <= quick_result;
            swap_reg   <= swap_pend_reg;
            err_reg    <= err_pend_reg;
            state_reg  <= ST_DONE;
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            result_reg <= iter_acc;
            swap_reg   <= swap_pend_reg;
            err_reg    <= 1'b0;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready)
            state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign result = result_reg;
  assign swap   = swap_reg;
  assign err    = err_reg;

endmodule
